// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control path:
// ALU ops, opcodes, FSM states and datapath select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    // S_FETCH must stay at encoding 0: it is the reset state
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BEQ, S_ILLEGAL
    } state_t;

    // What the current state asks of the ALU decoder
    typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_cls_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-op decode from state class and funct fields.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_t    alu_op,
    output logic       op_illegal
);

    always_comb begin
        alu_op     = ALU_ADD;
        op_illegal = 1'b0;
        case (cls)
            CLS_SUB: alu_op = ALU_SUB;
            CLS_R, CLS_I: begin
                case (funct3)
                    // funct7_5 is an immediate bit for addi, so only R-type honours it
                    F3_ADD:  alu_op = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_AND:  alu_op = ALU_AND;
                    F3_OR:   alu_op = ALU_OR;
                    default: op_illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core: sequences fetch through
// writeback and handshakes with the unified instruction/data memory.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       illegal
);

    state_t   state, state_n;
    alu_cls_t cls;
    alu_op_t  dec_op;
    logic     op_illegal;

    alu_decoder u_dec (
        .cls        (cls),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .alu_op     (dec_op),
        .op_illegal (op_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_n;
    end

    always_comb begin
        cls = CLS_ADD;
        case (state)
            S_EXEC_R: cls = CLS_R;
            S_EXEC_I: cls = CLS_I;
            S_BEQ:    cls = CLS_SUB;
            default:  ;
        endcase
    end

    always_comb begin
        state_n    = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_op     = dec_op;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                // old PC + imm lands in ALU_out as the branch target
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_R:         state_n = S_EXEC_R;
                    OP_I:         state_n = S_EXEC_I;
                    OP_LW, OP_SW: state_n = S_MEM_ADR;
                    OP_BEQ:       state_n = (funct3 == F3_BEQ) ? S_BEQ : S_ILLEGAL;
                    default:      state_n = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                if (funct3 != F3_W)       state_n = S_ILLEGAL;
                else if (opcode == OP_SW) state_n = S_MEM_WR;
                else                      state_n = S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_n = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MDR;
                state_n    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_n = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = (state == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                state_n   = op_illegal ? S_ILLEGAL : S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_n   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                pc_write  = zero;
                state_n   = S_FETCH;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   state_n = S_ILLEGAL;
        endcase
        // Reset silences everything combinationally so an in-flight write cannot complete
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_op     = 4'b0000;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output signatures per instruction.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [3:0] alu_op;
    logic [1:0] alu_src_a, alu_src_b, result_src;

    int checks = 0;
    int failures = 0;
    int rw_seen = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_we,adr_src,ir_write,pc_write,reg_write, alu_op, src_a, src_b, result_src, illegal}
    logic [16:0] obs;
    assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  alu_op, alu_src_a, alu_src_b, result_src, illegal};

    localparam logic [16:0] ZERO    = 17'b0;
    localparam logic [16:0] FETCH_R = {6'b100110, 4'b0010, 2'b00, 2'b10, 2'b10, 1'b0};
    localparam logic [16:0] FETCH_W = {6'b100000, 4'b0010, 2'b00, 2'b10, 2'b10, 1'b0};
    localparam logic [16:0] DECODE  = {6'b000000, 4'b0010, 2'b01, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] EXR_SUB = {6'b000000, 4'b0110, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] EXR_ADD = {6'b000000, 4'b0010, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] EXR_AND = {6'b000000, 4'b0000, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] EXR_OR  = {6'b000000, 4'b0001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] EXI_ADD = {6'b000000, 4'b0010, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] EXI_OR  = {6'b000000, 4'b0001, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] EXI_AND = {6'b000000, 4'b0000, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] ALU_WB  = {6'b000001, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] MEM_ADR = {6'b000000, 4'b0010, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] MEM_RD  = {6'b101000, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] MEM_WB  = {6'b000001, 4'b0010, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [16:0] MEM_WR  = {6'b111000, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] BEQ_T   = {6'b000010, 4'b0110, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] BEQ_N   = {6'b000000, 4'b0110, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] ILL     = {6'b000000, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b1};

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic        rdy;
        logic        z;
        logic        rs;
        logic [16:0] exp;
    } vec_t;

    function automatic vec_t v(logic [6:0] op, logic [2:0] f3, logic f75,
                               logic rdy, logic z, logic rs, logic [16:0] exp);
        vec_t t;
        t.op = op; t.f3 = f3; t.f75 = f75; t.rdy = rdy; t.z = z; t.rs = rs; t.exp = exp;
        return t;
    endfunction

    always @(posedge reg_write) rw_seen++;

    // ALU encoding must always be one of the four legal codes
    always @(negedge clk) begin
        checks++;
        if (!(alu_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110})) begin
            failures++;
            $display("FAIL alu_op_legal t=%0t got=%b want one of 0000/0001/0010/0110", $time, alu_op);
        end
    end

    task automatic test_reset();
        vec_t q[$];
        q.push_back(v(7'h33, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, ZERO));
        q.push_back(v(7'h33, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, ZERO));
        q.push_back(v(7'h33, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, FETCH_W));
        foreach (q[i]) begin
            rst = q[i].rs; opcode = q[i].op; funct3 = q[i].f3; funct7_5 = q[i].f75;
            mem_ready = q[i].rdy; zero = q[i].z;
            #1; checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL reset[%0d] got=%b want=%b", i, obs, q[i].exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        vec_t q[$];
        int npc = 0;
        logic [6:0] op = 7'b0110011;
        q.push_back(v(op, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, DECODE));
        q.push_back(v(op, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, EXR_SUB));
        q.push_back(v(op, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, ALU_WB));
        q.push_back(v(op, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, FETCH_W));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, EXR_ADD));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, ALU_WB));
        q.push_back(v(op, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(op, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, EXR_AND));
        q.push_back(v(op, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, ALU_WB));
        q.push_back(v(op, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(op, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, EXR_OR));
        q.push_back(v(op, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, ALU_WB));
        q.push_back(v(op, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, FETCH_W));
        foreach (q[i]) begin
            rst = q[i].rs; opcode = q[i].op; funct3 = q[i].f3; funct7_5 = q[i].f75;
            mem_ready = q[i].rdy; zero = q[i].z;
            #1; checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL rtype[%0d] got=%b want=%b", i, obs, q[i].exp);
            end
            if (i < 5 && pc_write) npc++;
            @(negedge clk);
        end
        checks++;
        if (npc != 1) begin
            failures++;
            $display("FAIL rtype_pc_pulses got=%0d want=1", npc);
        end
    endtask

    task automatic test_itype();
        vec_t q[$];
        logic [6:0] op = 7'b0010011;
        q.push_back(v(op, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(op, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, EXI_ADD));
        q.push_back(v(op, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, ALU_WB));
        q.push_back(v(op, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(op, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, EXI_OR));
        q.push_back(v(op, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, ALU_WB));
        q.push_back(v(op, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(op, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, EXI_AND));
        q.push_back(v(op, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, ALU_WB));
        q.push_back(v(op, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, FETCH_W));
        foreach (q[i]) begin
            rst = q[i].rs; opcode = q[i].op; funct3 = q[i].f3; funct7_5 = q[i].f75;
            mem_ready = q[i].rdy; zero = q[i].z;
            #1; checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL itype[%0d] got=%b want=%b", i, obs, q[i].exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem();
        vec_t q[$];
        logic [6:0] lw = 7'b0000011, sw = 7'b0100011;
        q.push_back(v(lw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, FETCH_W));
        q.push_back(v(lw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(lw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, DECODE));
        q.push_back(v(lw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, MEM_ADR));
        q.push_back(v(lw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, MEM_RD));
        q.push_back(v(lw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, MEM_RD));
        q.push_back(v(lw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, MEM_RD));
        q.push_back(v(lw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, MEM_RD));
        q.push_back(v(lw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, MEM_WB));
        q.push_back(v(sw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(sw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(sw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, MEM_ADR));
        q.push_back(v(sw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, MEM_WR));
        q.push_back(v(sw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, FETCH_W));
        foreach (q[i]) begin
            rst = q[i].rs; opcode = q[i].op; funct3 = q[i].f3; funct7_5 = q[i].f75;
            mem_ready = q[i].rdy; zero = q[i].z;
            #1; checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL mem[%0d] got=%b want=%b", i, obs, q[i].exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_beq();
        vec_t q[$];
        logic [6:0] op = 7'b1100011;
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, DECODE));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, BEQ_T));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, FETCH_R));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(op, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, BEQ_N));
        q.push_back(v(op, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, FETCH_W));
        foreach (q[i]) begin
            rst = q[i].rs; opcode = q[i].op; funct3 = q[i].f3; funct7_5 = q[i].f75;
            mem_ready = q[i].rdy; zero = q[i].z;
            #1; checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL beq[%0d] got=%b want=%b", i, obs, q[i].exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        vec_t q[$];
        logic [6:0] r = 7'b0110011, bad = 7'b1111111;
        q.push_back(v(r, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(r, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(r, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, EXR_ADD));
        for (int k = 0; k < 20; k++)
            q.push_back(v(r, 3'b001, 1'b0, 1'(k % 2), 1'(k % 3 == 0), 1'b0, ILL));
        q.push_back(v(r, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, ZERO));
        q.push_back(v(r, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, FETCH_W));
        q.push_back(v(bad, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(bad, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(bad, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, ILL));
        q.push_back(v(bad, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, ZERO));
        q.push_back(v(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, ILL));
        q.push_back(v(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, ZERO));
        q.push_back(v(7'b0000011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(7'b0000011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(7'b0000011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, MEM_ADR));
        q.push_back(v(7'b0000011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, ILL));
        q.push_back(v(7'b0000011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, ZERO));
        q.push_back(v(7'b0010011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(7'b0010011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(7'b0010011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, EXI_ADD));
        q.push_back(v(7'b0010011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, ILL));
        q.push_back(v(7'b0010011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, ZERO));
        q.push_back(v(7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, FETCH_W));
        foreach (q[i]) begin
            rst = q[i].rs; opcode = q[i].op; funct3 = q[i].f3; funct7_5 = q[i].f75;
            mem_ready = q[i].rdy; zero = q[i].z;
            #1; checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL illegal[%0d] got=%b want=%b", i, obs, q[i].exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_reset();
        vec_t q[$];
        logic [6:0] sw = 7'b0100011;
        rw_seen = 0;
        q.push_back(v(sw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, FETCH_R));
        q.push_back(v(sw, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, DECODE));
        q.push_back(v(sw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, MEM_ADR));
        q.push_back(v(sw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, MEM_WR));
        foreach (q[i]) begin
            rst = q[i].rs; opcode = q[i].op; funct3 = q[i].f3; funct7_5 = q[i].f75;
            mem_ready = q[i].rdy; zero = q[i].z;
            #1; checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL sw_rst[%0d] got=%b want=%b", i, obs, q[i].exp);
            end
            @(negedge clk);
        end
        // Still waiting in MEM_WR; reset lands between clock edges
        #1; checks++;
        if (obs !== MEM_WR) begin
            failures++;
            $display("FAIL sw_rst_hold got=%b want=%b", obs, MEM_WR);
        end
        #2 rst = 1'b1;
        #1; checks++;
        if ({mem_req, mem_we} !== 2'b00) begin
            failures++;
            $display("FAIL sw_rst_async got req/we=%b want=00", {mem_req, mem_we});
        end
        checks++;
        if (obs !== ZERO) begin
            failures++;
            $display("FAIL sw_rst_zero got=%b want=%b", obs, ZERO);
        end
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1; checks++;
        if (obs !== FETCH_W) begin
            failures++;
            $display("FAIL sw_rst_fetch got=%b want=%b", obs, FETCH_W);
        end
        checks++;
        if (rw_seen != 0) begin
            failures++;
            $display("FAIL sw_rst_regwrite got=%0d pulses want=0", rw_seen);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_mem();
        test_beq();
        test_illegal();
        test_sw_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I-subset core: the initiator side of the ALU. It sequences fetch/decode/execute/memory/writeback and drives `alu_op`, operand selects, and datapath strobes to the combinational ALU, then consumes the ALU `zero` flag for branches. It also runs a request/ready handshake with unified instruction/data memory. Supported instructions: `add`, `sub`, `and`, `or`, `addi`, `andi`, `ori`, `lw`, `sw`, `beq`. Anything else traps to a sticky illegal state.

## Interface
Parameters: none. Encodings are fixed in `riscv_ctrl_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7_5` in 1: `instr[30]`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current request.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: write enable, qualified by `mem_req`.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALU_out register.
- `ir_write` out 1: load the instruction register and the old-PC register.
- `pc_write` out 1: load the PC.
- `reg_write` out 1: register file write enable.
- `alu_op` out 4: AND = 0000, OR = 0001, ADD = 0010, SUB = 0110.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `result_src` out 2: 00 = ALU_out register, 01 = memory data register, 10 = live ALU result.
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BEQ, ILLEGAL.
- FETCH
  - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10.
  - Holds while `mem_ready`=0.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 (PC+4) in that cycle, then go to DECODE.
- DECODE
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, ADD. This latches the branch target into ALU_out.
  - Next state by opcode: 0110011 → EXEC_R; 0010011 → EXEC_I; 0000011 or 0100011 → MEM_ADR; 1100011 → BEQ (only if `funct3`=000); otherwise → ILLEGAL.
- EXEC_R / EXEC_I
  - Operands: `alu_src_a`=10; `alu_src_b`=00 (R) or 01 (I).
  - `alu_op` comes from the decoder. If the decoder flags the instruction illegal, go to ILLEGAL. Otherwise go to ALU_WB.
- ALU_WB: `reg_write`=1, `result_src`=00, then FETCH.
- MEM_ADR: `alu_src_a`=10, `alu_src_b`=01, ADD. Next is MEM_RD for `lw`, MEM_WR for `sw`. `funct3` other than 010 → ILLEGAL.
- MEM_RD: `mem_req`=1, `adr_src`=1. Holds until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `result_src`=01, then FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `adr_src`=1. Holds until `mem_ready`, then FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00. `pc_write`=`zero` in the same cycle. Then FETCH.
- ILLEGAL: all strobes 0, `illegal`=1. Only reset leaves this state.
- ALU decode:
  - R-type: f3=000 gives ADD (`funct7_5`=0) or SUB (`funct7_5`=1); 111 gives AND; 110 gives OR; anything else is illegal.
  - I-type: 000 ADD, 111 AND, 110 OR; anything else is illegal.
  - Never emit an encoding outside {0000, 0001, 0010, 0110}. Default output is ADD.

## Timing
- Moore outputs decode from the state register. Exception: `ir_write`/`pc_write` in FETCH and `pc_write` in BEQ are Mealy, on `mem_ready`/`zero` respectively.
- Reset: state = FETCH. While `rst`=1, every output is 0, including `mem_req` and `illegal`. The first request issues in the first cycle after deassertion.
- Reset mid-transaction drops `mem_req` asynchronously. No write may complete once `rst` is seen.
- Cycle counts with zero-wait memory (`mem_ready` high on request):
  - R/I-type: 4 cycles.
  - `lw`: 5 cycles.
  - `sw`: 4 cycles.
  - `beq`: 3 cycles.
- Each memory wait cycle adds one cycle. Outputs stay stable throughout a wait.
- `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.

## Structure
- `riscv_ctrl_pkg` holds:
  - `alu_op_t` enum. It is shared with the ALU, the ALU reference model, and the benches.
  - Opcode constants.
  - The `state_t` enum.
  - Select-encoding localparams.
- Sub-module `alu_decoder`: combinational map of (state class, `funct3`, `funct7_5`) to `alu_op` plus `op_illegal`.

## Test plan
- Reset, then `opcode`=0110011, f3=000, f7_5=1, `mem_ready` held 1:
  - Sequence FETCH → DECODE → EXEC_R(`alu_op`=0110) → ALU_WB(`reg_write`=1) → FETCH.
  - `pc_write` is pulsed once.
- `lw` (0000011, f3=010) with `mem_ready` low for 3 cycles in MEM_RD:
  - `mem_req`=1 and `adr_src`=1 are stable for 4 cycles.
  - MEM_WB follows with `result_src`=01 and `reg_write`=1.
- `beq` with `zero`=1, then repeat with `zero`=0:
  - BEQ shows `alu_op`=0110.
  - `pc_write`=1 only in the first run. Both runs take 3 cycles.
- Invalid ops:
  - `opcode`=0110011, f3=001 → ILLEGAL with `illegal`=1, held for 20 cycles.
  - Then `rst` pulse → `illegal`=0 and FETCH.
  - Also `opcode`=1111111 → ILLEGAL directly from DECODE.
- `sw` (0100011, f3=010): assert `rst` while in MEM_WR with `mem_ready`=0.
  - `mem_req` and `mem_we` drop to 0 asynchronously. `reg_write` is never asserted.
- Random instruction stream over 1000 instructions, scored against the reference model:
  - `alu_op` is always one of {0000, 0001, 0010, 0110}.
  - Coverage bins hit every state and every transition.
